// File: rtl/aes_pkg.sv
// Shared AES datapath types: byte, row and row-index definitions.
package aes_pkg;

  localparam int AES_NB = 4;
  localparam int AES_ROW_IDX_W = $clog2(AES_NB);

  typedef logic [7:0] byte_t;
  typedef byte_t [AES_NB-1:0] row_t;
  typedef logic [AES_ROW_IDX_W-1:0] row_idx_t;

  // Index width for an N-row counter; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/enc_row_rotator.sv
// Combinational N-byte left rotate by a variable byte amount.
// Output byte j takes input byte (j + amt) mod N; one mux per output byte.
module enc_row_rotator
  import aes_pkg::*;
#(
  parameter int N  = AES_NB,
  parameter int W  = $bits(byte_t),
  parameter int CW = idx_width(N)
) (
  input  logic [N-1:0][W-1:0] row_i,
  input  logic [CW-1:0]       amt_i,
  output logic [N-1:0][W-1:0] row_o
);

  // Per output byte, select the source byte addressed by the rotate amount.
  always_comb begin
    for (int j = 0; j < N; j++) begin
      row_o[j] = row_i[j];
      for (int k = 1; k < N; k++) begin
        if (amt_i == CW'(k)) begin
          row_o[j] = row_i[(j + k) % N];
        end
      end
    end
  end

endmodule

// File: rtl/enc_shifter.sv
// AES ShiftRows stage, one row per write. Rows are rotated left by their
// index within the state; done pulses alongside the last row of each state.
module enc_shifter
  import aes_pkg::*;
#(
  parameter int N = AES_NB,
  parameter int W = $bits(byte_t)
) (
  input  logic               clk,
  input  logic               resetn,   // active-high despite the name
  input  logic               wr_en,
  input  logic [N-1:0][W-1:0] inp,
  output logic [N-1:0][W-1:0] outp,
  output logic               done
);

  localparam int CW = idx_width(N);
  localparam logic [CW-1:0] LAST_ROW = CW'(N - 1);

  logic [N-1:0][W-1:0] outp_q, outp_d;
  logic [CW-1:0]       row_cnt_q, row_cnt_d;
  logic                done_q, done_d;
  logic [N-1:0][W-1:0] rot_row;

  enc_row_rotator #(
    .N  (N),
    .W  (W),
    .CW (CW)
  ) u_rotator (
    .row_i (inp),
    .amt_i (row_cnt_q),
    .row_o (rot_row)
  );

  // Next-state: a write loads the rotated row and advances the row counter;
  // otherwise output and counter hold and done drops.
  always_comb begin
    outp_d    = outp_q;
    row_cnt_d = row_cnt_q;
    done_d    = 1'b0;
    if (wr_en) begin
      outp_d    = rot_row;
      done_d    = (row_cnt_q == LAST_ROW);
      row_cnt_d = (row_cnt_q == LAST_ROW) ? '0 : row_cnt_q + CW'(1);
    end
  end

  // State registers; reset wins over a simultaneous write and restarts at row 0.
  always_ff @(posedge clk) begin
    if (resetn) begin
      outp_q    <= '0;
      row_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      outp_q    <= outp_d;
      row_cnt_q <= row_cnt_d;
      done_q    <= done_d;
    end
  end

  assign outp = outp_q;
  assign done = done_q;

endmodule

// File: tb/tb_enc_shifter.sv
module tb_enc_shifter;
  localparam int N = 4;
  localparam int W = 8;

  logic               clk;
  logic               resetn;
  logic               wr_en;
  logic [N-1:0][W-1:0] inp;
  logic [N-1:0][W-1:0] outp;
  logic               done;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int                 m_row = 0;
  logic [N-1:0][W-1:0] m_outp = '0;
  logic               m_done = 1'b0;

  typedef struct {
    logic        rst;
    logic        we;
    logic [31:0] din;
    logic [31:0] exp_outp;
    logic        exp_done;
  } vec_t;

  vec_t vecs[$];

  enc_shifter #(.N(N), .W(W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .wr_en  (wr_en),
    .inp    (inp),
    .outp   (outp),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(input logic rst, input logic we, input logic [31:0] din,
                              input logic [31:0] eo, input logic ed);
    vec_t v;
    v.rst = rst; v.we = we; v.din = din; v.exp_outp = eo; v.exp_done = ed;
    vecs.push_back(v);
  endfunction

  // Model: row r of a state is rotated left by r bytes; rows count modulo N.
  task automatic model_step(input logic rst, input logic we, input logic [N-1:0][W-1:0] d);
    if (rst) begin
      m_outp = '0; m_done = 1'b0; m_row = 0;
    end else if (we) begin
      for (int j = 0; j < N; j++) m_outp[j] = d[(j + m_row) % N];
      m_done = (m_row == N - 1);
      m_row  = (m_row + 1) % N;
    end else begin
      m_done = 1'b0;
    end
  endtask

  task automatic step(input logic rst, input logic we, input logic [N-1:0][W-1:0] d);
    @(negedge clk);
    resetn = rst; wr_en = we; inp = d;
    @(posedge clk);
    model_step(rst, we, d);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] eo, input logic ed);
    n_checks++;
    if (outp !== eo || done !== ed) begin
      n_fail++;
      $display("FAIL %s: got outp=%h done=%b, want outp=%h done=%b", name, outp, done, eo, ed);
    end
  endtask

  initial begin
    resetn = 1'b1; wr_en = 1'b0; inp = '0;

    // reset for two cycles, then release
    add(1, 0, 32'h0,        32'h0,        0);
    add(1, 0, 32'h0,        32'h0,        0);
    add(0, 0, 32'h0,        32'h0,        0);
    // full state, inp[0]=00
    add(0, 1, 32'h03020100, 32'h03020100, 0);
    add(0, 1, 32'h03020100, 32'h00030201, 0);
    add(0, 1, 32'h03020100, 32'h01000302, 0);
    add(0, 1, 32'h03020100, 32'h02010003, 1);
    // wrap back to row 0
    add(0, 1, 32'hd3c2b1a0, 32'hd3c2b1a0, 0);
    // hold: inp changes without wr_en
    add(0, 0, 32'hccddeeff, 32'hd3c2b1a0, 0);
    add(0, 0, 32'hccddeeff, 32'hd3c2b1a0, 0);
    add(0, 0, 32'hccddeeff, 32'hd3c2b1a0, 0);
    // counter held at row 1 across the idle cycles
    add(0, 1, 32'h03020100, 32'h00030201, 0);
    add(0, 1, 32'h03020100, 32'h01000302, 0);
    // mid-state reset, next write is row 0
    add(1, 0, 32'h03020100, 32'h0,        0);
    add(0, 1, 32'h13121110, 32'h13121110, 0);
    add(0, 1, 32'h03020100, 32'h00030201, 0);
    add(0, 1, 32'h03020100, 32'h01000302, 0);
    add(0, 1, 32'h03020100, 32'h02010003, 1);
    add(0, 0, 32'h03020100, 32'h02010003, 0);
    // reset and write on the same edge
    add(0, 1, 32'h03020100, 32'h03020100, 0);
    add(1, 1, 32'h77665544, 32'h0,        0);
    add(0, 1, 32'h03020100, 32'h03020100, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].we, vecs[i].din);
      check($sformatf("vec%0d", i), vecs[i].exp_outp, vecs[i].exp_done);
    end

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic r, w;
      logic [31:0] d;
      r = ($urandom_range(0, 15) == 0);
      w = ($urandom_range(0, 3) != 0);
      d = $urandom;
      step(r, w, d);
      check($sformatf("rnd%0d", i), m_outp, m_done);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
